// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg -- shared definitions for the hardware stack controller.
// Holds the op_code encodings and the controller FSM state enumeration.
package stack_ctrl_pkg;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        IDLE = 3'd1,
        DEC  = 3'd2,
        WR   = 3'd3,
        RD   = 3'd4,
        INC  = 3'd5,
        FIN  = 3'd6
    } state_t;

    // PUSH and CALL both store a word (data or return address) on the stack.
    function automatic logic is_store_op(input logic [1:0] code);
        return (code == OP_PUSH) || (code == OP_CALL);
    endfunction

endpackage

// File: rtl/stack_ctrl.sv
// stack_ctrl -- sequencer for a downward-growing hardware stack.
// The SP register, stack memory and program counter live outside this block;
// the controller only drives their control strobes.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   op_valid/op_ready        operation handshake (accept on valid && ready)
//   op_code/op_data/ret_pc   operation, PUSH word or CALL target, CALL return address
//   done/err/rd_data         completion pulse, rejection flag, popped word
//   sp_ld/sp_inc/sp_dec/sp_in/sp_q   external SP register control and value
//   mem_addr/mem_wdata/mem_we/mem_re/mem_ack/mem_rdata   stack memory request
//   pc_ld/pc_out             program counter load for CALL/RET
//
// Optional feature: define STACK_CTRL_BOUNDS_CHK_EN to reject overflowing
// PUSH/CALL and underflowing POP/RET (done with err=1, no side effects).
// Without it err is tied 0, SP wraps and the depth count saturates.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter logic [15:0] STACK_TOP = 16'hFFFF,
    parameter int unsigned DEPTH     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [15:0] op_data,
    input  logic [15:0] ret_pc,
    output logic        op_ready,
    output logic        done,
    output logic        err,
    output logic [15:0] rd_data,
    output logic        sp_ld,
    output logic        sp_inc,
    output logic        sp_dec,
    output logic [15:0] sp_in,
    input  logic [15:0] sp_q,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        pc_ld,
    output logic [15:0] pc_out
);

    state_t      state, state_nx;
    logic [15:0] depth;
    logic [15:0] rd_q;
    logic        rej_q;
    logic        reject;
    logic        accept;

    // Operation context, latched on accept; never needs a reset value.
    logic [1:0]  code_q;
    logic [15:0] data_q;
    logic [15:0] ret_q;
    logic [15:0] cap_q;

    assign accept = (state == IDLE) && op_valid;

`ifdef STACK_CTRL_BOUNDS_CHK_EN
    localparam logic [15:0] DEPTH_LIM = 16'(DEPTH);
    assign reject = is_store_op(op_code) ? (depth == DEPTH_LIM) : (depth == 16'd0);
`else
    assign reject = 1'b0;
`endif

    // Control state: FSM, depth count, held read data, rejection flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            depth <= 16'd0;
            rd_q  <= 16'd0;
            rej_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == INIT) begin
                depth <= 16'd0;
            end
            if (accept) begin
                rej_q <= reject;
            end
            // Saturating count; with bounds checking the limits are never reached.
            if ((state == WR) && mem_ack && (depth != 16'hFFFF)) begin
                depth <= depth + 16'd1;
            end
            if ((state == INC) && (depth != 16'd0)) begin
                depth <= depth - 16'd1;
            end
            if ((state == FIN) && !rej_q && !is_store_op(code_q)) begin
                rd_q <= cap_q;
            end
        end
    end

    // Operation context and memory read capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            code_q <= op_code;
            data_q <= op_data;
            ret_q  <= ret_pc;
        end
        if ((state == RD) && mem_ack) begin
            cap_q <= mem_rdata;
        end
    end

    always_comb begin
        state_nx  = state;
        op_ready  = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        rd_data   = rd_q;
        sp_ld     = 1'b0;
        sp_inc    = 1'b0;
        sp_dec    = 1'b0;
        sp_in     = 16'd0;
        mem_addr  = 16'd0;
        mem_wdata = 16'd0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        pc_ld     = 1'b0;
        pc_out    = 16'd0;

        unique case (state)
            INIT: begin
                sp_ld    = 1'b1;
                sp_in    = STACK_TOP;
                state_nx = IDLE;
            end
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    if (reject) begin
                        state_nx = FIN;
                    end else if (is_store_op(op_code)) begin
                        state_nx = DEC;
                    end else begin
                        state_nx = RD;
                    end
                end
            end
            DEC: begin
                // Pre-decrement: the write lands at the new SP in WR.
                sp_dec   = 1'b1;
                state_nx = WR;
            end
            WR: begin
                mem_we    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = (code_q == OP_CALL) ? ret_q : data_q;
                if (mem_ack) begin
                    state_nx = FIN;
                end
            end
            RD: begin
                mem_re   = 1'b1;
                mem_addr = sp_q;
                if (mem_ack) begin
                    state_nx = INC;
                end
            end
            INC: begin
                sp_inc   = 1'b1;
                state_nx = FIN;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
`ifdef STACK_CTRL_BOUNDS_CHK_EN
                err = rej_q;
`endif
                // A rejected operation has no PC or read-data effect.
                if (!rej_q) begin
                    unique case (code_q)
                        OP_POP: begin
                            rd_data = cap_q;
                        end
                        OP_CALL: begin
                            pc_ld  = 1'b1;
                            pc_out = data_q;
                        end
                        OP_RET: begin
                            pc_ld   = 1'b1;
                            pc_out  = cap_q;
                            rd_data = cap_q;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_nx = INIT;
        endcase

        // Reset forces every output low regardless of state.
        if (rst) begin
            op_ready  = 1'b0;
            done      = 1'b0;
            err       = 1'b0;
            rd_data   = 16'd0;
            sp_ld     = 1'b0;
            sp_inc    = 1'b0;
            sp_dec    = 1'b0;
            sp_in     = 16'd0;
            mem_addr  = 16'd0;
            mem_wdata = 16'd0;
            mem_we    = 1'b0;
            mem_re    = 1'b0;
            pc_ld     = 1'b0;
            pc_out    = 16'd0;
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl -- bench for stack_ctrl. Models the external SP register and
// stack memory (with programmable ack delay) and checks every operation
// against a queue-based stack reference.
module tb_stack_ctrl;
    import stack_ctrl_pkg::*;

    localparam logic [15:0] TOP = 16'hFFFF;
`ifdef STACK_CTRL_BOUNDS_CHK_EN
    localparam int DEP = 2;
`else
    localparam int DEP = 256;
`endif

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [15:0] op_data;
    logic [15:0] ret_pc;
    logic        op_ready;
    logic        done;
    logic        err;
    logic [15:0] rd_data;
    logic        sp_ld, sp_inc, sp_dec;
    logic [15:0] sp_in;
    logic [15:0] sp_q;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_we, mem_re, mem_ack;
    logic [15:0] mem_rdata;
    logic        pc_ld;
    logic [15:0] pc_out;

    stack_ctrl #(.STACK_TOP(TOP), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .op_data(op_data), .ret_pc(ret_pc), .op_ready(op_ready), .done(done),
        .err(err), .rd_data(rd_data), .sp_ld(sp_ld), .sp_inc(sp_inc),
        .sp_dec(sp_dec), .sp_in(sp_in), .sp_q(sp_q), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pc_ld(pc_ld), .pc_out(pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External SP register.
    logic [15:0] sp_reg = 16'h1234;
    assign sp_q = sp_reg;
    always @(posedge clk) begin
        if (sp_ld)       sp_reg <= sp_in;
        else if (sp_inc) sp_reg <= sp_reg + 16'd1;
        else if (sp_dec) sp_reg <= sp_reg - 16'd1;
    end

    // Stack memory: acks after ack_delay wait cycles of a held request.
    logic [15:0] mem [0:65535];
    int wait_cnt  = 0;
    int ack_delay = 0;
    assign mem_ack   = (mem_we || mem_re) && (wait_cnt == ack_delay);
    assign mem_rdata = mem_re ? mem[mem_addr] : 16'h0000;
    always @(posedge clk) begin
        if (mem_we && mem_ack) mem[mem_addr] <= mem_wdata;
        if (!(mem_we || mem_re) || mem_ack) wait_cnt <= 0;
        else                                wait_cnt <= wait_cnt + 1;
    end

    // Reference model: stack contents bottom..top, and last completed read word.
    logic [15:0] model[$];
    logic [15:0] last_rd = 16'h0000;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic do_op(input logic [1:0] code, input logic [15:0] data,
                         input logic [15:0] ret, input int d);
        int n, lat, we_n, re_n, dec_n, inc_n, pc_n, dec_cyc, inc_cyc, viol;
        logic [15:0] we_addr, we_data, re_addr, pc_v, rd_v, word, top;
        logic got_done, err_v, store, exp_err;
        ack_delay = d;
        store = (code == OP_PUSH) || (code == OP_CALL);
        exp_err = 1'b0;
`ifdef STACK_CTRL_BOUNDS_CHK_EN
        exp_err = store ? (model.size() == DEP) : (model.size() == 0);
`endif
        n = 0;
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("op_ready", op_ready, 1);
        op_valid = 1'b1; op_code = code; op_data = data; ret_pc = ret;
        @(posedge clk);
        #1;
        op_valid = 1'b0; op_code = 2'($urandom); op_data = 16'($urandom); ret_pc = 16'($urandom);

        lat = 0; we_n = 0; re_n = 0; dec_n = 0; inc_n = 0; pc_n = 0; viol = 0;
        dec_cyc = -1; inc_cyc = -1; got_done = 1'b0; err_v = 1'b0;
        we_addr = 0; we_data = 0; re_addr = 0; pc_v = 0; rd_v = 0;
        while (!got_done && lat < 100 + d) begin
            @(negedge clk);
            lat++;
            if (mem_we) begin we_n++; we_addr = mem_addr; we_data = mem_wdata; end
            if (mem_re) begin re_n++; re_addr = mem_addr; end
            if (mem_we && mem_re) viol++;
            if (int'(sp_ld) + int'(sp_inc) + int'(sp_dec) > 1) viol++;
            if (sp_dec) begin dec_n++; dec_cyc = lat; end
            if (sp_inc) begin inc_n++; inc_cyc = lat; end
            if (pc_ld)  begin pc_n++; pc_v = pc_out; end
            if (done)   begin got_done = 1'b1; err_v = err; rd_v = rd_data; end
        end
        chk("done_seen", got_done, 1);
        chk("exclusive_strobes", viol, 0);
        chk("err", err_v, exp_err);

        if (exp_err) begin
            chk("err_latency", lat, 1);
            chk("err_side_effects", we_n + re_n + dec_n + inc_n + pc_n, 0);
            chk("err_rd_hold", rd_v, last_rd);
        end else if (store) begin
            word = (code == OP_CALL) ? ret : data;
            chk("wr_latency", lat, d + 3);
            chk("sp_dec_cycle", dec_cyc, 1);
            chk("sp_dec_count", dec_n, 1);
            chk("sp_inc_count", inc_n, 0);
            chk("mem_we_cycles", we_n, d + 1);
            chk("mem_re_cycles", re_n, 0);
            chk("wr_addr", we_addr, 16'(TOP - 16'(model.size() + 1)));
            chk("wr_data", we_data, word);
            chk("pc_ld_count", pc_n, (code == OP_CALL) ? 1 : 0);
            if (code == OP_CALL) chk("call_pc", pc_v, data);
            chk("rd_hold", rd_v, last_rd);
            model.push_back(word);
        end else begin
            top = model[$];
            chk("rd_latency", lat, d + 3);
            chk("sp_inc_cycle", inc_cyc, d + 2);
            chk("sp_inc_count", inc_n, 1);
            chk("sp_dec_count", dec_n, 0);
            chk("mem_re_cycles", re_n, d + 1);
            chk("mem_we_cycles", we_n, 0);
            chk("rd_addr", re_addr, 16'(TOP - 16'(model.size())));
            if (code == OP_POP) begin
                chk("pop_data", rd_v, top);
                chk("pc_ld_count", pc_n, 0);
            end else begin
                chk("pc_ld_count", pc_n, 1);
                chk("ret_pc", pc_v, top);
            end
            void'(model.pop_back());
            last_rd = top;
        end

        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("sp_value", sp_reg, 16'(TOP - 16'(model.size())));
        chk("depth", dut.depth, 16'(model.size()));
    endtask

    initial begin
        logic       saw_done;
        logic [1:0] code;

        rst = 1'b1; op_valid = 1'b0; op_code = 2'b00; op_data = 16'h0; ret_pc = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_sp_ld", sp_ld, 0);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_req", mem_we | mem_re, 0);
        chk("rst_pc_ld", pc_ld, 0);
        chk("rst_depth", dut.depth, 0);
        rst = 1'b0;
        #1;
        chk("init_sp_ld", sp_ld, 1);
        chk("init_sp_in", sp_in, 16'hFFFF);
        chk("init_op_ready", op_ready, 0);
        @(negedge clk);
        chk("idle_op_ready", op_ready, 1);
        chk("idle_sp_ld", sp_ld, 0);
        chk("idle_sp", sp_reg, 16'hFFFF);

        do_op(OP_PUSH, 16'hA5A5, 16'h0000, 0);
        do_op(OP_POP,  16'h1111, 16'h2222, 4);
        do_op(OP_CALL, 16'h0100, 16'h0042, 1);
        do_op(OP_RET,  16'h3333, 16'h4444, 0);

`ifdef STACK_CTRL_BOUNDS_CHK_EN
        do_op(OP_PUSH, 16'h0001, 16'h0, 0);
        do_op(OP_PUSH, 16'h0002, 16'h0, 1);
        do_op(OP_PUSH, 16'h0003, 16'h0, 0);
        do_op(OP_CALL, 16'h0500, 16'h0777, 0);
        do_op(OP_POP,  16'h0, 16'h0, 0);
        do_op(OP_POP,  16'h0, 16'h0, 2);
        do_op(OP_POP,  16'h0, 16'h0, 0);
        do_op(OP_RET,  16'h0, 16'h0, 0);
`endif

        // Reset while a write is waiting for its ack.
        do_op(OP_PUSH, 16'h5A5A, 16'h0, 0);
        ack_delay = 50;
        op_valid = 1'b1; op_code = OP_PUSH; op_data = 16'hBEEF; ret_pc = 16'h0;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_in_wr", mem_we, 1);
        rst = 1'b1;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 0);
        chk("abort_rst_we", mem_we, 0);
        chk("abort_rst_rd", rd_data, 0);
        rst = 1'b0;
        #1;
        chk("abort_sp_ld", sp_ld, 1);
        chk("abort_sp_in", sp_in, 16'hFFFF);
        @(negedge clk);
        model.delete();
        last_rd = 16'h0000;
        chk("abort_ready", op_ready, 1);
        chk("abort_sp", sp_reg, 16'hFFFF);
        chk("abort_depth", dut.depth, 0);

        for (int i = 0; i < 60; i++) begin
            code = 2'($urandom_range(0, 3));
`ifndef STACK_CTRL_BOUNDS_CHK_EN
            if (model.size() == 0 && !((code == OP_PUSH) || (code == OP_CALL))) code = OP_PUSH;
`endif
            do_op(code, 16'($urandom), 16'($urandom), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter STACK_TOP, default 16'hFFFF: SP value when the stack is empty; the stack grows downward.
REQ-002 Parameter DEPTH, default 256: maximum number of stacked words, range 1..65535.
REQ-003 Ports, as "name direction width meaning":
- clk in 1: single clock, rising edge.
- rst in 1: reset, synchronous, active-high.
- op_valid in 1: operation request.
- op_code in 2: 00 PUSH, 01 POP, 10 CALL, 11 RET.
- op_data in 16: PUSH word or CALL target.
- ret_pc in 16: return address pushed by CALL.
- op_ready out 1: controller can accept an operation.
- done out 1: one-cycle completion pulse.
- err out 1: valid with done; operation rejected.
- rd_data out 16: popped word, valid with done.
- sp_ld, sp_inc, sp_dec out 1 each: SP register controls, at most one high per cycle.
- sp_in out 16: SP load value.
- sp_q in 16: SP register output.
- mem_addr out 16, mem_wdata out 16, mem_we out 1, mem_re out 1: memory request.
- mem_ack in 1: memory request complete; mem_rdata is valid with it on reads.
- mem_rdata in 16: memory read data.
- pc_ld out 1, pc_out out 16: program counter load, one cycle.

Function
REQ-004 FSM states SHALL be INIT, IDLE, DEC, WR, RD, INC, FIN.
REQ-005 INIT SHALL assert sp_ld with sp_in=STACK_TOP for exactly one cycle, set depth=0, then go to IDLE.
REQ-006 op_ready SHALL be 1 only in IDLE; an operation is accepted when op_valid&&op_ready, and op_code/op_data/ret_pc are latched at that edge.
REQ-007 PUSH/CALL path: IDLE->DEC, DEC->WR, WR->FIN.
- DEC: sp_dec=1 for one cycle.
- WR: mem_we=1, mem_addr=sp_q, mem_wdata=op_data (PUSH) or ret_pc (CALL); held stable until mem_ack.
REQ-008 POP/RET path: IDLE->RD, RD->INC, INC->FIN.
- RD: mem_re=1, mem_addr=sp_q; held until mem_ack; mem_rdata captured on the ack cycle.
- INC: sp_inc=1 for one cycle.
REQ-009 FIN SHALL pulse done for one cycle, then return to IDLE.
- POP: rd_data=captured word.
- CALL: pc_ld=1, pc_out=latched op_data.
- RET: pc_ld=1, pc_out=captured word.
REQ-010 depth SHALL increment when leaving WR and decrement when leaving INC; it is 16-bit unsigned with no wrap.
REQ-011 mem_ack SHALL be ignored outside WR/RD; mem_we and mem_re SHALL never be high together.
REQ-012 Minimum latency, accept to done: 3 cycles with mem_ack in the first WR/RD cycle.
REQ-013 rd_data SHALL hold its last value until the next POP/RET completes.

Reset
REQ-014 While rst=1, the FSM SHALL enter INIT and all outputs SHALL be 0, including rd_data and depth; SP initialisation occurs in the first cycle after rst deasserts.
REQ-015 rst asserted mid-operation SHALL abort the operation with no done pulse; the stack is re-initialised empty.

Configuration
REQ-016 With STACK_CTRL_BOUNDS_CHK_EN defined:
- PUSH/CALL at depth==DEPTH, or POP/RET at depth==0, SHALL go IDLE->FIN directly.
- FIN then asserts done=1 and err=1, with no sp_*, mem_* or pc_ld activity and depth unchanged.
REQ-017 Without STACK_CTRL_BOUNDS_CHK_EN:
- err SHALL be tied 0 and no bounds check is made.
- SP wraps modulo 2^16; depth saturates at 0 and 65535.

Structure
REQ-018 A shared package SHALL hold the op_code encodings (OP_PUSH, OP_POP, OP_CALL, OP_RET) and the FSM state enumeration.
REQ-019 The block is a single module with no sub-modules; the SP register, memory and PC are external.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset then idle: one cycle sp_ld=1 with sp_in=16'hFFFF, then op_ready=1.
- PUSH 16'hA5A5 with mem_ack immediate: sp_dec in cycle 1; write of 16'hA5A5 to addr 16'hFFFE; done in cycle 3; err=0.
- POP after that PUSH, mem_ack delayed 4 cycles: mem_re held 5 cycles at 16'hFFFE; then sp_inc; done with rd_data=16'hA5A5.
- CALL op_data=16'h0100, ret_pc=16'h0042, then RET: CALL gives pc_ld with pc_out=16'h0100; RET gives pc_ld with pc_out=16'h0042; SP returns to 16'hFFFF.
- Bounds (macro on, DEPTH=2): third PUSH gives done=1, err=1 and no mem_we; POP on an empty stack gives err=1.
- rst pulsed during WR wait: no done pulse; sp_ld of STACK_TOP occurs after rst falls; depth=0.
